// File: rtl/uart_rx_ctrl_pkg.sv
// rtl/uart_rx_ctrl_pkg.sv - shared register map, bit indices and defaults for uart_rx_ctrl
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA   = 3'd0,
    ADDR_STATUS = 3'd1,
    ADDR_CTRL   = 3'd2,
    ADDR_DIV_LO = 3'd3,
    ADDR_DIV_HI = 3'd4
  } reg_addr_e;

  localparam int STATUS_NOT_EMPTY = 0;
  localparam int STATUS_FULL      = 1;
  localparam int STATUS_OVERRUN   = 2;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam logic [15:0] DIV_RESET_DEFAULT = 16'd434;

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - receive FIFO; a push while full is accepted only alongside a pop
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // When full, the simultaneous pop frees the slot the push lands in.
  assign do_push = push & (~full | pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && rst_n) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - CPU register file, receive FIFO and interrupt for a UART receiver
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = DIV_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rx_en,
  output logic [31:0] clk_count_bit,
  input  logic [7:0]  rx_data,
  input  logic        rx_end,
  input  logic [2:0]  cpu_addr,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ctrl_enable;
  logic          ctrl_irq_en;
  logic          overrun;
  logic [15:0]   div;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          data_rd;
  logic          overrun_set;
  logic          overrun_clr;
  logic [7:0]    status;
  logic [7:0]    rd_val;

  assign rx_en         = ctrl_enable;
  assign clk_count_bit = {16'd0, div};
  assign data_rd       = cpu_re && (cpu_addr == ADDR_DATA);
  // A pop in the same cycle makes room, so only an unpopped full FIFO overruns.
  assign overrun_set   = rx_end & fifo_full & ~data_rd;
  assign overrun_clr   = cpu_we && (cpu_addr == ADDR_STATUS) && cpu_wdata[STATUS_OVERRUN];

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_end),
    .pop   (data_rd),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status = 8'h00;
    status[STATUS_NOT_EMPTY] = (fifo_count != '0);
    status[STATUS_FULL]      = fifo_full;
    status[STATUS_OVERRUN]   = overrun;
  end

  always_comb begin
    rd_val = 8'h00;
    case (cpu_addr)
      ADDR_DATA:   rd_val = fifo_empty ? 8'h00 : fifo_dout;
      ADDR_STATUS: rd_val = status;
      ADDR_CTRL:   rd_val = {6'd0, ctrl_irq_en, ctrl_enable};
      ADDR_DIV_LO: rd_val = div[7:0];
      ADDR_DIV_HI: rd_val = div[15:8];
      default:     rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_enable <= 1'b0;
      ctrl_irq_en <= 1'b0;
      overrun     <= 1'b0;
      div         <= DIV_RESET;
      cpu_rdata   <= 8'h00;
      irq         <= 1'b0;
    end else begin
      if (cpu_re) cpu_rdata <= rd_val;

      if (overrun_set)      overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;

      if (cpu_we) begin
        case (cpu_addr)
          ADDR_CTRL: begin
            ctrl_enable <= cpu_wdata[CTRL_ENABLE];
            ctrl_irq_en <= cpu_wdata[CTRL_IRQ_EN];
          end
          ADDR_DIV_LO: if (!ctrl_enable) div[7:0]  <= cpu_wdata;
          ADDR_DIV_HI: if (!ctrl_enable) div[15:8] <= cpu_wdata;
          default: ;
        endcase
      end

      irq <= ctrl_irq_en & (status[STATUS_NOT_EMPTY] | overrun);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        rx_en;
  logic [31:0] clk_count_bit;
  logic [7:0]  rx_data;
  logic        rx_end;
  logic [2:0]  cpu_addr;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        irq;

  int tests_run;
  int tests_failed;

  logic [7:0]  m_q[$];
  logic        m_ovr;
  logic [7:0]  m_ctrl;
  logic [15:0] m_div;
  logic [7:0]  m_rdata;

  uart_rx_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .DIV_RESET  (16'd434)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_en         (rx_en),
    .clk_count_bit (clk_count_bit),
    .rx_data       (rx_data),
    .rx_end        (rx_end),
    .cpu_addr      (cpu_addr),
    .cpu_we        (cpu_we),
    .cpu_re        (cpu_re),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .irq           (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    cpu_addr = a;
    cpu_re   = 1'b1;
    cycle();
    cpu_re   = 1'b0;
    d        = cpu_rdata;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] wd);
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_we    = 1'b1;
    cycle();
    cpu_we    = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b;
    rx_end  = 1'b1;
    cycle();
    rx_end  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    m_q.delete();
    m_ovr   = 1'b0;
    m_ctrl  = 8'h00;
    m_div   = 16'd434;
    m_rdata = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] exp_tab [8];
    logic [7:0] d;
    exp_tab = '{8'h00, 8'h00, 8'h00, 8'hB2, 8'h01, 8'h00, 8'h00, 8'h00};
    do_reset();
    tests_run++;
    if (rx_en !== 1'b0 || irq !== 1'b0 || cpu_rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: rx_en=%b irq=%b rdata=%h, expected 0 0 00", rx_en, irq, cpu_rdata);
    end
    tests_run++;
    if (clk_count_bit !== 32'd434) begin
      tests_failed++;
      $display("FAIL reset_div: got %0d expected 434", clk_count_bit);
    end
    for (int a = 0; a < 8; a++) begin
      cpu_read(3'(a), d);
      tests_run++;
      if (d !== exp_tab[a]) begin
        tests_failed++;
        $display("FAIL reset_read_addr%0d: got %h expected %h", a, d, exp_tab[a]);
      end
    end
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] d;
    cpu_write(3'd2, 8'h03);
    tests_run++;
    if (rx_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_rx_en: got %b expected 1", rx_en);
    end
    rx_push(8'h5A);
    cpu_read(3'd1, d);
    tests_run++;
    if (d !== 8'h01 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_status_irq: status=%h irq=%b, expected 01 1", d, irq);
    end
    cpu_read(3'd0, d);
    tests_run++;
    if (d !== 8'h5A) begin
      tests_failed++;
      $display("FAIL single_data: got %h expected 5a", d);
    end
    cpu_read(3'd1, d);
    tests_run++;
    if (d !== 8'h00 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_after_pop: status=%h irq=%b, expected 00 0", d, irq);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    for (int i = 1; i <= 5; i++) rx_push(8'(i * 8'h11));
    cpu_read(3'd1, d);
    tests_run++;
    if (d !== 8'h07) begin
      tests_failed++;
      $display("FAIL overrun_status: got %h expected 07", d);
    end
    for (int i = 1; i <= 4; i++) begin
      cpu_read(3'd0, d);
      tests_run++;
      if (d !== 8'(i * 8'h11)) begin
        tests_failed++;
        $display("FAIL overrun_data%0d: got %h expected %h", i, d, 8'(i * 8'h11));
      end
    end
    cpu_read(3'd1, d);
    tests_run++;
    if (d !== 8'h04) begin
      tests_failed++;
      $display("FAIL overrun_sticky: got %h expected 04", d);
    end
    cpu_write(3'd1, 8'h04);
    cpu_read(3'd1, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL overrun_clear: got %h expected 00", d);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] d;
    logic [7:0] exp_tab [4];
    exp_tab = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 1; i <= 4; i++) rx_push(8'(i * 8'h11));
    rx_data  = 8'h66;
    rx_end   = 1'b1;
    cpu_addr = 3'd0;
    cpu_re   = 1'b1;
    cycle();
    rx_end   = 1'b0;
    cpu_re   = 1'b0;
    tests_run++;
    if (cpu_rdata !== 8'h11) begin
      tests_failed++;
      $display("FAIL fullpp_pop: got %h expected 11", cpu_rdata);
    end
    cpu_read(3'd1, d);
    tests_run++;
    if (d !== 8'h03) begin
      tests_failed++;
      $display("FAIL fullpp_status: got %h expected 03", d);
    end
    for (int i = 0; i < 4; i++) begin
      cpu_read(3'd0, d);
      tests_run++;
      if (d !== exp_tab[i]) begin
        tests_failed++;
        $display("FAIL fullpp_data%0d: got %h expected %h", i, d, exp_tab[i]);
      end
    end
    cpu_read(3'd0, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL empty_read: got %h expected 00", d);
    end
    cpu_read(3'd1, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL empty_read_status: got %h expected 00", d);
    end
  endtask

  task automatic test_div_and_regs();
    logic [7:0] d;
    cpu_write(3'd3, 8'h10);
    tests_run++;
    if (clk_count_bit !== 32'd434) begin
      tests_failed++;
      $display("FAIL div_locked: got %h expected 1b2", clk_count_bit);
    end
    cpu_write(3'd2, 8'h00);
    tests_run++;
    if (rx_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL ctrl_disable: rx_en=%b expected 0", rx_en);
    end
    cpu_write(3'd3, 8'h10);
    tests_run++;
    if (clk_count_bit !== 32'h110) begin
      tests_failed++;
      $display("FAIL div_write: got %h expected 110", clk_count_bit);
    end
    cpu_write(3'd1, 8'h03);
    cpu_write(3'd5, 8'hFF);
    cpu_read(3'd5, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL unmapped_read: got %h expected 00", d);
    end
    cpu_read(3'd1, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL status_readonly: got %h expected 00", d);
    end
    cpu_addr  = 3'd2;
    cpu_wdata = 8'hFE;
    cpu_we    = 1'b1;
    cpu_re    = 1'b1;
    cycle();
    cpu_we    = 1'b0;
    cpu_re    = 1'b0;
    tests_run++;
    if (cpu_rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL we_re_prewrite: got %h expected 00", cpu_rdata);
    end
    cycle();
    tests_run++;
    if (cpu_rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL rdata_hold: got %h expected 00", cpu_rdata);
    end
    cpu_read(3'd2, d);
    tests_run++;
    if (d !== 8'h02) begin
      tests_failed++;
      $display("FAIL ctrl_mask: got %h expected 02", d);
    end
  endtask

  task automatic test_random();
    logic        do_rx, do_re, do_we, pre_ne, pre_full, ovr_set, clr;
    logic        exp_irq;
    logic [7:0]  b, wd, pre_status, pre_ctrl;
    logic [2:0]  a;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      do_rx = ($urandom_range(0, 9) < 4);
      do_re = ($urandom_range(0, 9) < 5);
      do_we = ($urandom_range(0, 9) < 2);
      b     = 8'($urandom);
      wd    = 8'($urandom);
      if (do_we) a = 3'($urandom_range(0, 7));
      else       a = ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(0, 7));

      pre_ne     = (m_q.size() != 0);
      pre_full   = (m_q.size() == DEPTH);
      pre_status = {5'd0, m_ovr, pre_full, pre_ne};
      pre_ctrl   = m_ctrl;
      exp_irq    = m_ctrl[1] & (pre_ne | m_ovr);

      if (do_re) begin
        case (a)
          3'd0:    m_rdata = pre_ne ? m_q[0] : 8'h00;
          3'd1:    m_rdata = pre_status;
          3'd2:    m_rdata = m_ctrl;
          3'd3:    m_rdata = m_div[7:0];
          3'd4:    m_rdata = m_div[15:8];
          default: m_rdata = 8'h00;
        endcase
        if (a == 3'd0 && pre_ne) void'(m_q.pop_front());
      end
      ovr_set = 1'b0;
      if (do_rx) begin
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else                    ovr_set = 1'b1;
      end
      clr = do_we && (a == 3'd1) && wd[2];
      if (do_we && a == 3'd2) m_ctrl = {6'd0, wd[1:0]};
      if (do_we && a == 3'd3 && !pre_ctrl[0]) m_div[7:0]  = wd;
      if (do_we && a == 3'd4 && !pre_ctrl[0]) m_div[15:8] = wd;
      m_ovr = ovr_set ? 1'b1 : (clr ? 1'b0 : m_ovr);

      rx_end    = do_rx;
      rx_data   = b;
      cpu_re    = do_re;
      cpu_we    = do_we;
      cpu_addr  = a;
      cpu_wdata = wd;
      cycle();
      rx_end = 1'b0;
      cpu_re = 1'b0;
      cpu_we = 1'b0;

      tests_run++;
      if (cpu_rdata !== m_rdata || irq !== exp_irq) begin
        tests_failed++;
        $display("FAIL random_rd_irq cycle %0d: rdata=%h irq=%b, expected %h %b", n, cpu_rdata, irq, m_rdata, exp_irq);
      end
      tests_run++;
      if (rx_en !== m_ctrl[0] || clk_count_bit !== {16'd0, m_div}) begin
        tests_failed++;
        $display("FAIL random_ctrl_div cycle %0d: rx_en=%b div=%h, expected %b %h", n, rx_en, clk_count_bit, m_ctrl[0], m_div);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    cpu_write(3'd2, 8'h03);
    rx_push(8'hAA);
    rx_push(8'hBB);
    rst_n    = 1'b0;
    rx_data  = 8'hCC;
    rx_end   = 1'b1;
    cpu_addr = 3'd0;
    cpu_re   = 1'b1;
    cycle();
    rst_n  = 1'b1;
    rx_end = 1'b0;
    cpu_re = 1'b0;
    tests_run++;
    if (rx_en !== 1'b0 || cpu_rdata !== 8'h00 || irq !== 1'b0 || clk_count_bit !== 32'd434) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: rx_en=%b rdata=%h irq=%b div=%0d, expected 0 00 0 434", rx_en, cpu_rdata, irq, clk_count_bit);
    end
    cpu_read(3'd1, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_status: got %h expected 00", d);
    end
    cpu_read(3'd2, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_ctrl: got %h expected 00", d);
    end
    cpu_read(3'd0, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_data: got %h expected 00", d);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_end    = 1'b0;
    cpu_addr  = 3'd0;
    cpu_we    = 1'b0;
    cpu_re    = 1'b0;
    cpu_wdata = 8'h00;

    test_reset();
    test_single_byte();
    test_overrun();
    test_full_push_pop();
    test_div_and_regs();
    test_random();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
